// File: rtl/io_control_pkg.sv
// Shared types, defaults and the mode decode for the user-handshake controller.
package io_control_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int SYNC_STAGES_DEFAULT     = 2;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    ARMED        = 3'd1,
    WAIT_PRESS   = 3'd2,
    DEBOUNCE     = 3'd3,
    FIRE         = 3'd4,
    WAIT_RELEASE = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    MODE_NONE   = 2'd0,
    MODE_INPUT  = 2'd1,
    MODE_OUTPUT = 2'd2,
    MODE_PAUSE  = 2'd3
  } mode_e;

  // Both request lines together mean PAUSE; a single one selects INPUT or OUTPUT.
  function automatic mode_e decode_mode(input logic is_input, input logic is_output);
    mode_e m;
    case ({is_input, is_output})
      2'b11:   m = MODE_PAUSE;
      2'b10:   m = MODE_INPUT;
      2'b01:   m = MODE_OUTPUT;
      default: m = MODE_NONE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/io_handshake_controller_if.sv
// Handshake bundle between the control core / board pins and the controller.
interface io_handshake_controller_if;
  logic       is_input;
  logic       is_output;
  logic       confirm_key;
  logic       continue_key;
  logic       confirmation;
  logic       continue_button;
  logic       waiting_for_user;
  logic [2:0] state;

  modport master (
    output is_input, is_output, confirm_key, continue_key,
    input  confirmation, continue_button, waiting_for_user, state
  );

  modport slave (
    input  is_input, is_output, confirm_key, continue_key,
    output confirmation, continue_button, waiting_for_user, state
  );
endinterface

// File: rtl/button_synchronizer.sv
// Multi-flop synchronizer bringing a raw board button into the clock domain.
module button_synchronizer
  import io_control_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_chain;

  // Shift the raw level through the chain; reset clears every stage.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) r_chain <= '0;
    else          r_chain <= {r_chain[STAGES-2:0], i_async};
  end

  assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/io_handshake_controller.sv
// Turns debounced, fresh button presses into one-cycle confirmation / continue pulses.
//
// state        | meaning
// IDLE         | no request, or re-evaluating a new request
// ARMED        | selected button still held from an earlier action, waiting for release
// WAIT_PRESS   | request active, waiting for the button to go down
// DEBOUNCE     | button down, counting stable samples
// FIRE         | press accepted, pulse issued next cycle
// WAIT_RELEASE | waiting for a stable release before accepting another request
module io_handshake_controller
  import io_control_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
  input logic                      i_clock,
  input logic                      i_reset,
  io_handshake_controller_if.slave hs
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] C_FULL = CW'(DEBOUNCE_CYCLES);

  localparam logic [2:0] ST_IDLE         = IDLE;
  localparam logic [2:0] ST_ARMED        = ARMED;
  localparam logic [2:0] ST_WAIT_PRESS   = WAIT_PRESS;
  localparam logic [2:0] ST_DEBOUNCE     = DEBOUNCE;
  localparam logic [2:0] ST_FIRE         = FIRE;
  localparam logic [2:0] ST_WAIT_RELEASE = WAIT_RELEASE;

  logic [2:0]    r_state, w_state_nx;
  logic [CW-1:0] r_count, w_count_nx, w_count_inc;
  mode_e         r_mode, w_mode_nx, w_mode;
  logic          r_confirmation, r_continue;
  logic          w_confirm_btn, w_continue_btn;
  logic          w_btn_now, w_btn_latched, w_mode_changed;

  button_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_confirm (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_async (hs.confirm_key),
    .o_sync  (w_confirm_btn)
  );

  button_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_continue (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_async (hs.continue_key),
    .o_sync  (w_continue_btn)
  );

  assign w_mode         = decode_mode(hs.is_input, hs.is_output);
  // IDLE picks the button from the live request; every later state uses the latched one.
  assign w_btn_now      = (w_mode == MODE_PAUSE) ? w_continue_btn : w_confirm_btn;
  assign w_btn_latched  = (r_mode == MODE_PAUSE) ? w_continue_btn : w_confirm_btn;
  assign w_mode_changed = (w_mode != r_mode);
  assign w_count_inc    = (r_count == C_FULL) ? r_count : r_count + C_ONE;

  // Next-state and shared debounce counter decisions.
  always_comb begin
    w_state_nx = r_state;
    w_count_nx = r_count;
    w_mode_nx  = r_mode;
    case (r_state)
      ST_IDLE: begin
        w_count_nx = '0;
        if (w_mode != MODE_NONE) begin
          w_mode_nx  = w_mode;
          w_state_nx = w_btn_now ? ST_ARMED : ST_WAIT_PRESS;
        end
      end
      ST_ARMED: begin
        if (w_mode_changed) begin
          w_state_nx = ST_IDLE;
          w_count_nx = '0;
        end else if (w_btn_latched) begin
          w_count_nx = '0;
        end else if (w_count_inc == C_FULL) begin
          w_state_nx = ST_WAIT_PRESS;
          w_count_nx = '0;
        end else begin
          w_count_nx = w_count_inc;
        end
      end
      ST_WAIT_PRESS: begin
        if (w_mode_changed) begin
          w_state_nx = ST_IDLE;
          w_count_nx = '0;
        end else if (w_btn_latched) begin
          w_state_nx = ST_DEBOUNCE;
          w_count_nx = C_ONE;
        end
      end
      ST_DEBOUNCE: begin
        if (w_mode_changed) begin
          w_state_nx = ST_IDLE;
          w_count_nx = '0;
        end else if (!w_btn_latched) begin
          w_state_nx = ST_WAIT_PRESS;
          w_count_nx = '0;
        end else if (r_count == C_LAST) begin
          w_state_nx = ST_FIRE;
          w_count_nx = '0;
        end else begin
          w_count_nx = w_count_inc;
        end
      end
      ST_FIRE: begin
        w_state_nx = ST_WAIT_RELEASE;
        w_count_nx = '0;
      end
      ST_WAIT_RELEASE: begin
        if (w_btn_latched) begin
          w_count_nx = '0;
        end else if (w_count_inc == C_FULL) begin
          w_state_nx = ST_IDLE;
          w_count_nx = '0;
        end else begin
          w_count_nx = w_count_inc;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_count_nx = '0;
      end
    endcase
  end

  // State, counter, latched mode and registered pulses.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state        <= ST_IDLE;
      r_count        <= '0;
      r_mode         <= MODE_NONE;
      r_confirmation <= 1'b0;
      r_continue     <= 1'b0;
    end else begin
      r_state        <= w_state_nx;
      r_count        <= w_count_nx;
      r_mode         <= w_mode_nx;
      r_confirmation <= (r_state == ST_FIRE) && (r_mode != MODE_PAUSE);
      r_continue     <= (r_state == ST_FIRE) && (r_mode == MODE_PAUSE);
    end
  end

  assign hs.confirmation     = r_confirmation;
  assign hs.continue_button  = r_continue;
  assign hs.state            = r_state;
  assign hs.waiting_for_user = (r_state == ST_ARMED) || (r_state == ST_WAIT_PRESS) ||
                               (r_state == ST_DEBOUNCE);

endmodule

// File: tb/tb_io_handshake_controller.sv
// Bench for io_handshake_controller with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_io_handshake_controller;
  localparam int DEB = 4;
  localparam int SYNC = 2;
  localparam int LAT = SYNC + DEB + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   conf_cnt = 0, cont_cnt = 0, conf_last = -1, cont_last = -1, dbl_cnt = 0;
  logic conf_prev = 1'b0, cont_prev = 1'b0;

  io_handshake_controller_if hs();

  io_handshake_controller #(.DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .hs      (hs)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // pulse recorder: counts, last cycle seen and back-to-back pulses
  always @(negedge clk) begin
    if (hs.confirmation) begin
      conf_cnt++; conf_last = cyc; if (conf_prev) dbl_cnt++;
    end
    if (hs.continue_button) begin
      cont_cnt++; cont_last = cyc; if (cont_prev) dbl_cnt++;
    end
    conf_prev = hs.confirmation;
    cont_prev = hs.continue_button;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick(3);
    checks++; if (hs.state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", hs.state); end
    checks++; if (hs.confirmation !== 1'b0 || hs.continue_button !== 1'b0) begin errors++; $display("FAIL reset_pulses: got %b%b want 00", hs.confirmation, hs.continue_button); end
    checks++; if (hs.waiting_for_user !== 1'b0) begin errors++; $display("FAIL reset_waiting: got %b want 0", hs.waiting_for_user); end
    checks++; if (dut.r_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", dut.r_count); end
    rst_n = 1'b1;
    tick(3);
    checks++; if (hs.state !== 3'd0) begin errors++; $display("FAIL idle_no_request: got %0d want 0", hs.state); end
  endtask

  task automatic test_output_press;
    int c0, e0;
    hs.is_output = 1'b1;
    tick(3);
    checks++; if (hs.state !== 3'd2 || hs.waiting_for_user !== 1'b1) begin errors++; $display("FAIL out_wait_press: state %0d wait %b want 2/1", hs.state, hs.waiting_for_user); end
    c0 = conf_cnt; e0 = cyc;
    hs.confirm_key = 1'b1;
    tick(LAT - 1);
    checks++; if (hs.confirmation !== 1'b0 || hs.state !== 3'd4) begin errors++; $display("FAIL out_pre_pulse: conf %b state %0d want 0/4", hs.confirmation, hs.state); end
    tick(1);
    checks++; if (hs.confirmation !== 1'b1 || hs.state !== 3'd5) begin errors++; $display("FAIL out_pulse_at_7: conf %b state %0d at cycle %0d want 1/5", hs.confirmation, hs.state, cyc - e0); end
    tick(1);
    checks++; if (hs.confirmation !== 1'b0) begin errors++; $display("FAIL out_pulse_width: got %b want 0", hs.confirmation); end
    tick(3);
    hs.confirm_key = 1'b0;
    tick(DEB + SYNC - 1);
    checks++; if (hs.state !== 3'd5) begin errors++; $display("FAIL out_release_early: got %0d want 5", hs.state); end
    tick(1);
    checks++; if (hs.state !== 3'd0) begin errors++; $display("FAIL out_release_idle: got %0d want 0", hs.state); end
    tick(1);
    checks++; if (conf_cnt - c0 !== 1 || cont_cnt !== 0) begin errors++; $display("FAIL out_pulse_count: conf %0d cont %0d want 1/0", conf_cnt - c0, cont_cnt); end
  endtask

  task automatic test_pause_bounce;
    int c0, k0;
    hs.is_input = 1'b1; hs.is_output = 1'b1;
    tick(3);
    checks++; if (hs.state !== 3'd2) begin errors++; $display("FAIL pause_wait_press: got %0d want 2", hs.state); end
    c0 = conf_cnt; k0 = cont_cnt;
    hs.continue_key = 1'b1; tick(3); hs.continue_key = 1'b0;
    tick(8);
    checks++; if (cont_cnt - k0 !== 0 || hs.state !== 3'd2) begin errors++; $display("FAIL pause_bounce: pulses %0d state %0d want 0/2", cont_cnt - k0, hs.state); end
    hs.continue_key = 1'b1;
    tick(LAT);
    checks++; if (hs.continue_button !== 1'b1 || hs.confirmation !== 1'b0) begin errors++; $display("FAIL pause_pulse: cont %b conf %b want 1/0", hs.continue_button, hs.confirmation); end
    tick(2); hs.continue_key = 1'b0;
    tick(10);
    checks++; if (cont_cnt - k0 !== 1 || conf_cnt - c0 !== 0) begin errors++; $display("FAIL pause_count: cont %0d conf %0d want 1/0", cont_cnt - k0, conf_cnt - c0); end
  endtask

  task automatic test_armed;
    int c0;
    hs.is_input = 1'b0; hs.is_output = 1'b0;
    tick(2);
    hs.confirm_key = 1'b1;
    tick(3);
    hs.is_input = 1'b1;
    tick(1);
    checks++; if (hs.state !== 3'd1 || hs.waiting_for_user !== 1'b1) begin errors++; $display("FAIL armed_entry: state %0d wait %b want 1/1", hs.state, hs.waiting_for_user); end
    c0 = conf_cnt;
    tick(6);
    hs.confirm_key = 1'b0; tick(2); hs.confirm_key = 1'b1;
    tick(6);
    checks++; if (hs.state !== 3'd1) begin errors++; $display("FAIL armed_blip: got %0d want 1", hs.state); end
    hs.confirm_key = 1'b0;
    tick(DEB + 1);
    checks++; if (hs.state !== 3'd1) begin errors++; $display("FAIL armed_release_early: got %0d want 1", hs.state); end
    tick(1);
    checks++; if (hs.state !== 3'd2) begin errors++; $display("FAIL armed_to_wait_press: got %0d want 2", hs.state); end
    checks++; if (conf_cnt - c0 !== 0) begin errors++; $display("FAIL armed_no_pulse: got %0d want 0", conf_cnt - c0); end
    hs.confirm_key = 1'b1;
    tick(LAT);
    checks++; if (hs.confirmation !== 1'b1) begin errors++; $display("FAIL armed_new_press: got %b want 1", hs.confirmation); end
    tick(2); hs.confirm_key = 1'b0;
    tick(10);
    checks++; if (conf_cnt - c0 !== 1) begin errors++; $display("FAIL armed_count: got %0d want 1", conf_cnt - c0); end
  endtask

  task automatic test_drop;
    int c0;
    c0 = conf_cnt;
    hs.confirm_key = 1'b1;
    tick(SYNC + 2);
    checks++; if (hs.state !== 3'd3 || dut.r_count !== 3'd2) begin errors++; $display("FAIL drop_debounce: state %0d count %0d want 3/2", hs.state, dut.r_count); end
    hs.is_input = 1'b0;
    tick(1);
    checks++; if (hs.state !== 3'd0 || dut.r_count !== 3'd0 || hs.waiting_for_user !== 1'b0) begin errors++; $display("FAIL drop_idle: state %0d count %0d wait %b want 0/0/0", hs.state, dut.r_count, hs.waiting_for_user); end
    tick(8);
    hs.confirm_key = 1'b0;
    tick(4);
    checks++; if (conf_cnt - c0 !== 0) begin errors++; $display("FAIL drop_no_pulse: got %0d want 0", conf_cnt - c0); end
  endtask

  task automatic test_reset_mid;
    int c0;
    hs.is_output = 1'b1;
    tick(2);
    checks++; if (hs.state !== 3'd2) begin errors++; $display("FAIL rmid_wait_press: got %0d want 2", hs.state); end
    c0 = conf_cnt;
    hs.confirm_key = 1'b1;
    tick(SYNC + 2);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (hs.state !== 3'd0 || hs.confirmation !== 1'b0 || hs.waiting_for_user !== 1'b0) begin errors++; $display("FAIL rmid_debounce_async: state %0d conf %b wait %b want 0/0/0", hs.state, hs.confirmation, hs.waiting_for_user); end
    hs.confirm_key = 1'b0;
    tick(2); rst_n = 1'b1;
    tick(12);
    checks++; if (conf_cnt - c0 !== 0 || hs.state !== 3'd2) begin errors++; $display("FAIL rmid_debounce_after: pulses %0d state %0d want 0/2", conf_cnt - c0, hs.state); end
    hs.confirm_key = 1'b1;
    tick(LAT - 1);
    checks++; if (hs.state !== 3'd4) begin errors++; $display("FAIL rmid_fire_state: got %0d want 4", hs.state); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (hs.state !== 3'd0 || hs.confirmation !== 1'b0) begin errors++; $display("FAIL rmid_fire_async: state %0d conf %b want 0/0", hs.state, hs.confirmation); end
    hs.confirm_key = 1'b0;
    tick(2); rst_n = 1'b1;
    tick(12);
    checks++; if (conf_cnt - c0 !== 0) begin errors++; $display("FAIL rmid_fire_no_pulse: got %0d want 0", conf_cnt - c0); end
  endtask

  task automatic test_both_keys;
    int c0, k0;
    c0 = conf_cnt; k0 = cont_cnt;
    hs.confirm_key = 1'b1; hs.continue_key = 1'b1;
    tick(LAT);
    checks++; if (hs.confirmation !== 1'b1 || hs.continue_button !== 1'b0) begin errors++; $display("FAIL both_pulse: conf %b cont %b want 1/0", hs.confirmation, hs.continue_button); end
    tick(4);
    hs.confirm_key = 1'b0; hs.continue_key = 1'b0;
    tick(10);
    checks++; if (conf_cnt - c0 !== 1 || cont_cnt - k0 !== 0 || hs.state !== 3'd2) begin errors++; $display("FAIL both_count: conf %0d cont %0d state %0d want 1/0/2", conf_cnt - c0, cont_cnt - k0, hs.state); end
  endtask

  // Model: a press fires iff the selected key stays high >= DEB cycles; the pulse lands
  // SYNC+DEB+1 cycles after the rising edge on the output chosen by the mode; the other key is noise.
  task automatic test_random;
    for (int it = 0; it < 24; it++) begin
      int m, len, gap, e0, sel0, oth0, sel_d, oth_d, sel_last, want;
      m = $urandom_range(0, 2);
      len = $urandom_range(1, 8);
      gap = $urandom_range(0, 4);
      hs.is_input  = (m == 0 || m == 2);
      hs.is_output = (m == 1 || m == 2);
      tick(3);
      checks++; if (hs.state !== 3'd2) begin errors++; $display("FAIL rand_ready it%0d: state %0d want 2", it, hs.state); end
      sel0 = (m == 2) ? cont_cnt : conf_cnt;
      oth0 = (m == 2) ? conf_cnt : cont_cnt;
      e0 = cyc;
      for (int k = 0; k < len; k++) begin
        if (m == 2) begin hs.continue_key = 1'b1; hs.confirm_key = 1'($urandom_range(0, 1)); end
        else        begin hs.confirm_key = 1'b1; hs.continue_key = 1'($urandom_range(0, 1)); end
        tick(1);
      end
      hs.confirm_key = 1'b0; hs.continue_key = 1'b0;
      tick(10 + gap);
      sel_d = ((m == 2) ? cont_cnt : conf_cnt) - sel0;
      oth_d = ((m == 2) ? conf_cnt : cont_cnt) - oth0;
      sel_last = (m == 2) ? cont_last : conf_last;
      want = (len >= DEB) ? 1 : 0;
      checks++; if (sel_d !== want) begin errors++; $display("FAIL rand_pulses it%0d mode%0d len%0d: got %0d want %0d", it, m, len, sel_d, want); end
      checks++; if (oth_d !== 0) begin errors++; $display("FAIL rand_other it%0d mode%0d: got %0d want 0", it, m, oth_d); end
      if (want == 1) begin
        checks++; if (sel_last !== e0 + LAT) begin errors++; $display("FAIL rand_latency it%0d: got %0d want %0d", it, sel_last - e0, LAT); end
      end
    end
    checks++; if (dbl_cnt !== 0) begin errors++; $display("FAIL no_double_pulse: got %0d want 0", dbl_cnt); end
  endtask

  initial begin
    hs.is_input = 1'b0; hs.is_output = 1'b0;
    hs.confirm_key = 1'b0; hs.continue_key = 1'b0;
    test_reset;
    test_output_press;
    test_pause_bounce;
    test_armed;
    test_drop;
    test_reset_mid;
    test_both_keys;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_handshake_controller.md
# io_handshake_controller

Sequences the user-handshake instructions (INPUT, OUTPUT, PAUSE) between the board push-buttons and the control core. It synchronizes and debounces the confirmation and continue buttons. It requires each press to be a fresh press, and delivers exactly one single-cycle `confirmation` or `continue_button` pulse per accepted press. This lets the core's `enable` advance the PC once per user action. It sits between the board I/O pins and the control unit.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable synchronized samples required to accept a press or release (10 ms at 50 MHz); minimum 2.
- `SYNC_STAGES`, default 2: flip-flop depth of each button synchronizer; minimum 2.

- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `is_input`  in  1  from control core.
- `is_output`  in  1  from control core.
- `confirm_key`  in  1  raw board confirmation button, active-high, asynchronous.
- `continue_key`  in  1  raw board continue button, active-high, asynchronous.
- `confirmation`  out  1  single-cycle pulse to the core (INPUT/OUTPUT).
- `continue_button`  out  1  single-cycle pulse to the core (PAUSE).
- `waiting_for_user`  out  1  high while a press is awaited (LED).
- `state`  out  3  current FSM state, for debug display.

## Operation
- Mode decode, combinational, per cycle:
  - PAUSE = `is_input & is_output`, uses the continue button.
  - INPUT = `is_input` only, uses the confirmation button.
  - OUTPUT = `is_output` only, uses the confirmation button.
  - NONE otherwise.
- The selected button is called `btn` (synchronized value).
- The mode is latched on leaving IDLE.
- FSM states:
  - IDLE: mode NONE → stay. Mode ≠ NONE: `btn`=0 → WAIT_PRESS, `btn`=1 → ARMED. Latch mode.
  - ARMED: the button was held from a previous action. Count consecutive `btn`=0 cycles; reaching DEBOUNCE_CYCLES → WAIT_PRESS. Any `btn`=1 clears the count.
  - WAIT_PRESS: `btn`=1 → DEBOUNCE, counter←1.
  - DEBOUNCE: `btn`=0 → WAIT_PRESS, counter←0. When `btn`=1 and counter = DEBOUNCE_CYCLES−1 → FIRE. Otherwise counter+1.
  - FIRE: exactly one cycle. Pulse the output matching the latched mode. → WAIT_RELEASE.
  - WAIT_RELEASE: count consecutive `btn`=0 cycles against the latched button; reaching DEBOUNCE_CYCLES → IDLE.
- Request dropped or mode changed in ARMED, WAIT_PRESS or DEBOUNCE: go to IDLE, clear the counter, no pulse. IDLE re-evaluates the new mode on the next cycle.
- Mode change in FIRE or WAIT_RELEASE is ignored; the release must still complete. Back-to-back I/O instructions therefore always need a release followed by a new press.
- The non-selected button is ignored entirely. Simultaneous presses: only the latched mode's button counts.
- `waiting_for_user` = state ∈ {ARMED, WAIT_PRESS, DEBOUNCE}.
- Counter width: $clog2(DEBOUNCE_CYCLES+1). It saturates and never wraps.

## Timing
- Reset (asynchronous assert, synchronous-to-clock release handled by the reset tree):
  - `state` = IDLE (0), counter = 0, synchronizers = 0.
  - `confirmation` = `continue_button` = `waiting_for_user` = 0.
- Pulse outputs are registered, high exactly one clock per FIRE, never two consecutive cycles.
- Latency, with the raw key rising at cycle 0 and the FSM in WAIT_PRESS:
  - `btn` visible at cycle SYNC_STAGES.
  - DEBOUNCE entered at SYNC_STAGES+1.
  - Pulse at cycle SYNC_STAGES+DEBOUNCE_CYCLES+1.
- Reset mid-DEBOUNCE or mid-FIRE: no pulse is emitted and the FSM returns to IDLE immediately.

## Structure
- Package `io_control_pkg`:
  - state enum: IDLE=0, ARMED=1, WAIT_PRESS=2, DEBOUNCE=3, FIRE=4, WAIT_RELEASE=5.
  - mode enum: MODE_NONE, MODE_INPUT, MODE_OUTPUT, MODE_PAUSE.
  - Parameter defaults.
- Sub-module `button_synchronizer` (SYNC_STAGES-deep flop chain, async active-low reset), instantiated twice.
- Single debounce counter shared across ARMED, DEBOUNCE and WAIT_RELEASE.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
1. `is_output`=1, confirm_key low, then high at cycle 0 and held → `confirmation` high only at cycle 7, state then 5; release held 4+2 cycles → state 0.
2. `is_input`=`is_output`=1, continue_key high for 3 cycles then low (bounce) → no pulse, state back to WAIT_PRESS; a subsequent 4-cycle-stable press → one `continue_button` pulse, `confirmation` stays 0.
3. Key held through FIRE while the next instruction is INPUT → ARMED, `waiting_for_user`=1, no second pulse until key low ≥4 cycles then pressed again.
4. `is_input` drops to 0 during DEBOUNCE (counter=2) → IDLE, no pulse, counter=0.
5. `reset` asserted mid-DEBOUNCE, asynchronously between edges → all outputs 0 and state 0 within the same cycle; no pulse after release.
6. Both keys pressed together in OUTPUT mode → exactly one `confirmation` pulse, `continue_button` never asserted.
